dual_port_word_bram: RTL and testbench
======================================

// Module: dual_port_word_bram
// PURPOSE
//   Responder end of the instruction/data cache debug interface (A2/WD2/WE2/RD2).
//   Word-organised dual-port RAM: port 1 serves the RV32I core, port 2 serves the
//   debug loader/dumper. Both ports use byte write enables and have 1-cycle read latency.
//   Instantiated twice in RV32ICore, once as InstCache and once as DataCache.
// PARAMETERS
//   ADDR_WIDTH  12  word-index bits; depth = 2**ADDR_WIDTH words (4096 = 16 KiB)
//   DATA_WIDTH  32  word width; fixed at 32, other values unsupported
// PORTS
//   CPU_CLK  in   1   single clock; all state changes on its rising edge
//   CPU_RST  in   1   reset; synchronous, active-high
//   A1       in   32  port-1 byte address (core)
//   WD1      in   32  port-1 write data
//   WE1      in   4   port-1 byte write enables; bit i -> WD1[8i+7:8i]
//   RD1      out  32  port-1 registered read data
//   A2       in   32  port-2 byte address (debug)
//   WD2      in   32  port-2 write data
//   WE2      in   4   port-2 byte write enables
//   RD2      out  32  port-2 registered read data
// BEHAVIOUR
//   Addressing: word index = A[ADDR_WIDTH+1:2]. A[1:0] ignored, no alignment trap.
//     A[31:ADDR_WIDTH+2] ignored, so addresses alias modulo the depth
//     (A2=32'hfffffffc -> word 4095; +4 wraps to word 0).
//   Write: at posedge, each set WEx[i] updates byte lane i of mem[idx_x]. WEx=4'b0000: no write.
//   Read: every posedge, RDx <= mem[idx_x] (value before any write in the same edge).
//     Latency is 1 cycle. Reads are read-first on the same port and across ports.
//     No read enable; RDx updates every cycle.
//   Collision: both ports write the same word in the same edge -> port 2 wins on
//     overlapping byte lanes. Non-overlapping lanes from each port are both written.
//   Reset: while CPU_RST=1 at an edge, RD1 <= 0 and RD2 <= 0, and the read is discarded.
//     Writes asserted in a reset cycle are still performed. Memory contents are never
//     cleared by reset. Power-up contents are undefined (X in simulation).
//     Reset mid-access: the next non-reset edge returns normal data for its address.
//   No handshake and no stalls: either port may change A/WE/WD every cycle.
//     Back-to-back write-then-read of the same word on consecutive edges returns the new data.
//   Implementation must infer block RAM: no reset on the array, and the byte-lane write loop
//     must be a for-loop over 4 lanes.
// TESTING
//   1 Load: port 2 writes word k = 32'hA5000000+k at A2=4k, WE2=4'hF, k=0..15.
//     Then port 2 reads each address; RD2 one cycle later = 32'hA5000000+k.
//   2 Byte lanes: mem[3]=32'h11223344; port 1 A1=12, WE1=4'b0101, WD1=32'hAABBCCDD.
//     Next read of A1=12 = 32'h11BB33DD.
//   3 Read-first: mem[5]=32'h1; same edge A1=20, WE1=4'hF, WD1=32'h2.
//     RD1 = 32'h1 after that edge, then 32'h2 after the next edge with WE1=0.
//   4 Collision: same edge, A1=A2=40, WE1=4'b0011, WD1=32'h0000BEEF,
//     WE2=4'b0110, WD2=32'h00CAFE00. Starting from mem[10]=0: mem[10]=32'h00CAFEEF.
//   5 Wrap/alias: write 32'h12345678 at A2=32'h00004000 (ADDR_WIDTH=12).
//     Reads at A1=0 and at A2=32'hFFFFC000 both return 32'h12345678.
//   6 Reset: with mem[0]=32'hDEADBEEF, hold CPU_RST=1 for 2 edges while A1=A2=0 and
//     port 2 writes mem[1]=32'h7. RD1=RD2=0 during reset; mem[0] is kept;
//     mem[1]=32'h7; the first edge after reset gives RD1=32'hDEADBEEF.

Source files
------------

// File: rtl/dual_port_word_bram_if.sv
// Bundles both address/write/read channels of the word RAM.
// Port 1 carries core traffic, port 2 carries debug loader/dumper traffic.
// No handshake: every field may change each cycle, RD1/RD2 follow 1 cycle later.
interface dual_port_word_bram_if;
   logic [31:0] A1;
   logic [31:0] WD1;
   logic [3:0]  WE1;
   logic [31:0] RD1;
   logic [31:0] A2;
   logic [31:0] WD2;
   logic [3:0]  WE2;
   logic [31:0] RD2;

   // Requester side drives addresses and writes, samples read data.
   modport master (
      output A1, WD1, WE1, A2, WD2, WE2,
      input  RD1, RD2
   );

   // Responder side (the RAM itself).
   modport slave (
      input  A1, WD1, WE1, A2, WD2, WE2,
      output RD1, RD2
   );
endinterface

// File: rtl/dual_port_word_bram.sv
// Word-organised dual-port RAM with byte write enables, used as instruction and data cache.
// Latency: 1 cycle, read-first on both ports; port 2 wins overlapping byte lanes on collision.
// Backpressure: none, both ports accept a new access every cycle.
module dual_port_word_bram #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32   // only 32 is supported
) (
   input  logic                 CPU_CLK,
   input  logic                 CPU_RST,
   dual_port_word_bram_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int LANES = DATA_WIDTH / 8;

   // No reset on the array so it maps onto block RAM; contents survive CPU_RST.
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] idx1;
   logic [ADDR_WIDTH-1:0] idx2;

   // Byte offset and bits above the depth are dropped, so addresses alias modulo the depth.
   assign idx1 = bus.A1[ADDR_WIDTH+1:2];
   assign idx2 = bus.A2[ADDR_WIDTH+1:2];

   logic unusedAddrBits;
   assign unusedAddrBits = ^{bus.A1[31:ADDR_WIDTH+2], bus.A1[1:0],
                             bus.A2[31:ADDR_WIDTH+2], bus.A2[1:0]};

   // Byte-lane writes; port 2 is assigned last so it wins lanes both ports write.
   always_ff @(posedge CPU_CLK) begin
      for (int i = 0; i < LANES; i++) begin
         if (bus.WE1[i]) begin
            mem[idx1][8*i +: 8] <= bus.WD1[8*i +: 8];
         end
         if (bus.WE2[i]) begin
            mem[idx2][8*i +: 8] <= bus.WD2[8*i +: 8];
         end
      end
   end

   // Registered reads return the word as it was before this edge's writes; reset zeroes them.
   always_ff @(posedge CPU_CLK) begin
      if (CPU_RST) begin
         bus.RD1 <= '0;
         bus.RD2 <= '0;
      end else begin
         bus.RD1 <= mem[idx1];
         bus.RD2 <= mem[idx2];
      end
   end
endmodule

// File: tb/tb_dual_port_word_bram.sv
// Scoreboard bench for dual_port_word_bram: directed cases plus randomized traffic.
// Expected read data comes from a byte-lane memory model with per-byte known flags.
// Checks are done by a negedge monitor popping one expectation per port per cycle.
module tb_dual_port_word_bram;
   localparam int AW    = 12;
   localparam int DEPTH = 1 << AW;

   typedef struct packed {
      logic [31:0] dat;
      logic [31:0] mask;
   } exp_t;

   logic CPU_CLK = 1'b0;
   logic CPU_RST;

   dual_port_word_bram_if bus ();

   dual_port_word_bram #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(32)
   ) dut (
      .CPU_CLK(CPU_CLK),
      .CPU_RST(CPU_RST),
      .bus    (bus)
   );

   always #5 CPU_CLK = ~CPU_CLK;

   int checks = 0;
   int fails  = 0;

   exp_t q1[$];
   exp_t q2[$];

   logic [31:0] mdl   [DEPTH];
   logic [3:0]  known [DEPTH];

   // Optional hard-coded expectations for the directed cases.
   logic        pin1 = 1'b0;
   logic        pin2 = 1'b0;
   logic [31:0] pinVal1;
   logic [31:0] pinVal2;

   function automatic logic [31:0] laneMask(input logic [3:0] k);
      logic [31:0] m;
      m = '0;
      for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{k[l]}};
      return m;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input exp_t e);
      if (e.mask != 32'h0) begin
         checks++;
         if ((act & e.mask) !== (e.dat & e.mask)) begin
            fails++;
            $display("FAIL %s: got %h, want %h (mask %h) at %0t", nm, act, e.dat, e.mask, $time);
         end
      end
   endtask

   // One clock of stimulus: drive both ports, record expected read data, update the model.
   task automatic step(input logic [31:0] a1, input logic [31:0] wd1, input logic [3:0] we1,
                       input logic [31:0] a2, input logic [31:0] wd2, input logic [3:0] we2,
                       input logic rst);
      int   i1;
      int   i2;
      exp_t e1;
      exp_t e2;
      bus.A1  = a1;  bus.WD1 = wd1; bus.WE1 = we1;
      bus.A2  = a2;  bus.WD2 = wd2; bus.WE2 = we2;
      CPU_RST = rst;
      i1 = int'(a1 % (DEPTH * 4)) / 4;
      i2 = int'(a2 % (DEPTH * 4)) / 4;
      if (rst) begin
         e1 = '{dat: 32'h0, mask: 32'hFFFFFFFF};
         e2 = '{dat: 32'h0, mask: 32'hFFFFFFFF};
      end else begin
         e1 = '{dat: mdl[i1], mask: laneMask(known[i1])};
         e2 = '{dat: mdl[i2], mask: laneMask(known[i2])};
      end
      if (pin1) e1 = '{dat: pinVal1, mask: 32'hFFFFFFFF};
      if (pin2) e2 = '{dat: pinVal2, mask: 32'hFFFFFFFF};
      pin1 = 1'b0;
      pin2 = 1'b0;
      q1.push_back(e1);
      q2.push_back(e2);
      for (int l = 0; l < 4; l++) begin
         if (we1[l]) begin
            mdl[i1][8*l +: 8] = wd1[8*l +: 8];
            known[i1][l] = 1'b1;
         end
      end
      for (int l = 0; l < 4; l++) begin
         if (we2[l]) begin
            mdl[i2][8*l +: 8] = wd2[8*l +: 8];
            known[i2][l] = 1'b1;
         end
      end
      @(posedge CPU_CLK);
      #1;
   endtask

   function automatic logic [31:0] randAddr();
      logic [31:0] r;
      int          idx;
      r   = $urandom();
      idx = ($urandom_range(0, 3) == 0) ? (DEPTH - 8 + int'($urandom_range(0, 7)))
                                        : int'($urandom_range(0, 31));
      return (r & 32'hFFFFC003) | (32'(idx) << 2);
   endfunction

   // Monitor: each cycle the DUT presents one read per port; compare against the scoreboard.
   always @(negedge CPU_CLK) begin
      if (q1.size() > 0) cmp("RD1", bus.RD1, q1.pop_front());
      if (q2.size() > 0) cmp("RD2", bus.RD2, q2.pop_front());
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a1, a2, wd1, wd2;
      logic [3:0]  we1, we2;
      logic        rst;

      for (int i = 0; i < DEPTH; i++) known[i] = 4'h0;

      // Reset state: both read ports zero while reset is held.
      step(0, 0, 0, 0, 0, 0, 1'b1);
      step(0, 0, 0, 0, 0, 0, 1'b1);

      // Load 16 words through port 2, then dump them back.
      for (int k = 0; k < 16; k++) step(0, 0, 0, 32'(4*k), 32'hA5000000 + 32'(k), 4'hF, 1'b0);
      for (int k = 0; k < 16; k++) begin
         pin2 = 1'b1; pinVal2 = 32'hA5000000 + 32'(k);
         step(0, 0, 0, 32'(4*k), 0, 0, 1'b0);
      end

      // Byte lanes on port 1.
      step(0, 0, 0, 12, 32'h11223344, 4'hF, 1'b0);
      step(12, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 1'b0);
      pin1 = 1'b1; pinVal1 = 32'h11BB33DD;
      step(12, 0, 0, 0, 0, 0, 1'b0);

      // Read-first on the writing port, then new data on the following read.
      step(0, 0, 0, 20, 32'h1, 4'hF, 1'b0);
      pin1 = 1'b1; pinVal1 = 32'h1;
      step(20, 32'h2, 4'hF, 0, 0, 0, 1'b0);
      pin1 = 1'b1; pinVal1 = 32'h2;
      step(20, 0, 0, 0, 0, 0, 1'b0);

      // Collision: port 2 owns the overlapping lane.
      step(0, 0, 0, 40, 32'h0, 4'hF, 1'b0);
      step(40, 32'h0000BEEF, 4'b0011, 40, 32'h00CAFE00, 4'b0110, 1'b0);
      pin1 = 1'b1; pinVal1 = 32'h00CAFEEF;
      pin2 = 1'b1; pinVal2 = 32'h00CAFEEF;
      step(40, 0, 0, 40, 0, 0, 1'b0);

      // Address aliasing above the depth.
      step(0, 0, 0, 32'h00004000, 32'h12345678, 4'hF, 1'b0);
      pin1 = 1'b1; pinVal1 = 32'h12345678;
      pin2 = 1'b1; pinVal2 = 32'h12345678;
      step(0, 0, 0, 32'hFFFFC000, 0, 0, 1'b0);
      step(0, 0, 0, 32'hFFFFFFFC, 32'hCAFEF00D, 4'hF, 1'b0);
      pin1 = 1'b1; pinVal1 = 32'h12345678;
      pin2 = 1'b1; pinVal2 = 32'hCAFEF00D;
      step(32'h00003FFC + 32'h4, 0, 0, 32'h00003FFC, 0, 0, 1'b0);

      // Reset keeps memory and still performs writes.
      step(0, 0, 0, 0, 32'hDEADBEEF, 4'hF, 1'b0);
      step(0, 0, 0, 4, 32'h7, 4'hF, 1'b1);
      step(0, 0, 0, 4, 32'h7, 4'hF, 1'b1);
      pin1 = 1'b1; pinVal1 = 32'hDEADBEEF;
      pin2 = 1'b1; pinVal2 = 32'h7;
      step(0, 0, 0, 4, 0, 0, 1'b0);

      // Randomized traffic with collisions, aliasing and occasional reset.
      for (int n = 0; n < 3000; n++) begin
         a1  = randAddr();
         a2  = ($urandom_range(0, 4) == 0) ? a1 : randAddr();
         wd1 = $urandom();
         wd2 = $urandom();
         we1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         we2 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 39) == 0);
         step(a1, wd1, we1, a2, wd2, we2, rst);
      end

      step(0, 0, 0, 0, 0, 0, 1'b0);
      @(negedge CPU_CLK);
      #1;
      checks++;
      if ((q1.size() + q2.size()) != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expectations, want 0", q1.size() + q2.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
